msi_message_generator: RTL

MSI_MESSAGE_GENERATOR -- requirements
Module: msi_message_generator

---
 rtl/msi_message_generator_if.sv | 12 +
 rtl/msi_message_generator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/msi_message_generator_if.sv
// Memory-write request channel from the MSI generator towards the TLP builder.
interface msi_message_generator_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  wr_vector;
    logic        msg_sent;

    modport master (output wr_valid, wr_addr, wr_data, wr_vector, msg_sent, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_vector, msg_sent, output wr_ready);
endinterface

// File: rtl/msi_message_generator.sv
// MSI message generator: pending-bit capture, vector arbitration and one-DW write requests.
// Define MSI_GEN_RR_ARB_EN for round-robin arbitration; default is lowest-vector-first.
module msi_message_generator (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msi_enable,
    input  logic [2:0]              multiple_message_enable,
    input  logic [63:0]             msg_addr,
    input  logic                    addr_64bit_capable,
    input  logic [15:0]             msg_data,
    input  logic [15:0]             ext_msg_data,
    input  logic                    ext_msg_data_enable,
    input  logic                    per_vector_masking,
    input  logic [31:0]             mask_bits,
    input  logic [31:0]             irq_req,
    output logic [31:0]             pending_bits,
    msi_message_generator_if.master wr
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  vec_q, vec_d;

    logic [2:0]  mme;
    logic [4:0]  vec_mask;
    logic [15:0] data_mask;
    logic [31:0] alloc_mask, set_vec, clr_vec, eligible;
    logic [4:0]  sel_vec;
    logic        sel_found;
    logic        accept;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^msg_addr[1:0];

    // MME 6/7 are reserved encodings and saturate to 32 vectors.
    always_comb begin
        mme       = (multiple_message_enable > 3'd5) ? 3'd5 : multiple_message_enable;
        vec_mask  = 5'((32'd1 << mme) - 32'd1);
        data_mask = {11'h0, vec_mask};
        alloc_mask = '0;
        set_vec    = '0;
        for (int v = 0; v < 32; v++) begin
            alloc_mask[v] = (5'(v) <= vec_mask);
            if (irq_req[v])
                set_vec[5'(v) & vec_mask] = 1'b1;
        end
        eligible = pending_q & alloc_mask & (per_vector_masking ? ~mask_bits : 32'hFFFF_FFFF);
    end

`ifdef MSI_GEN_RR_ARB_EN
    logic [4:0] ptr_q, ptr_d;
    logic [4:0] rr_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_vec   = '0;
        rr_idx    = '0;
        for (int i = 0; i < 32; i++) begin
            rr_idx = ptr_q + 5'(i);
            if (!sel_found && eligible[rr_idx]) begin
                sel_found = 1'b1;
                sel_vec   = rr_idx;
            end
        end
        ptr_d = accept ? ((vec_q + 5'd1) & vec_mask) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel_found = |eligible;
        sel_vec   = '0;
        for (int i = 31; i >= 0; i--) begin
            if (eligible[i])
                sel_vec = 5'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        vec_d   = vec_q;
        clr_vec = '0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (msi_enable && sel_found) begin
                    state_d = SEND;
                    vec_d   = sel_vec;
                    addr_d  = {addr_64bit_capable ? msg_addr[63:32] : 32'h0, msg_addr[31:2], 2'b00};
                    data_d  = {ext_msg_data_enable ? ext_msg_data : 16'h0000,
                               (msg_data & ~data_mask) | ({11'h0, sel_vec} & data_mask)};
                end
            end
            SEND: begin
                if (wr.wr_ready) begin
                    state_d        = IDLE;
                    accept         = 1'b1;
                    clr_vec[vec_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A request landing on the accept edge re-arms the bit being cleared.
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            vec_q     <= vec_d;
        end
    end

    assign pending_bits = pending_q;
    assign wr.wr_valid  = (state_q == SEND);
    assign wr.wr_addr   = addr_q;
    assign wr.wr_data   = data_q;
    assign wr.wr_vector = vec_q;
    assign wr.msg_sent  = accept && !rst;
endmodule
